// File: rtl/mult_div_32.sv
// Iterative MIPS HI/LO unit: MULT/MULTU (shift-add), DIV/DIVU (restoring), MTHI/MTLO.
// Latency: 33 busy cycles, done pulses the cycle after; start is ignored while busy.
module mult_div_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state_q;
    logic                 div_q;
    logic                 neg_q;      // sign of product / quotient
    logic                 rem_neg_q;  // sign of remainder follows dividend
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     hi_q, lo_q, hi_d, lo_d;
    logic                 done_q;

    logic                 sgn_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;

    always_comb begin
        sgn_op = ~op[0];
        abs_a  = (sgn_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        abs_b  = (sgn_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;

        // Multiply: add multiplicand into the upper half when the next multiplier bit is set.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};

        // Divide: shift one dividend bit into the partial remainder, subtract if it fits.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = (rem_sh >= {1'b0, b_q});
        div_diff = rem_sh[WIDTH-1:0] - b_q;

        acc_d = div_q ? {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
                      : {mul_sum, acc_q[WIDTH-1:1]};

        prod_fix = neg_q ? -acc_q : acc_q;
        if (div_q) begin
            hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = (b_q == '0) ? {WIDTH{1'b1}}
                 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !op[2]) begin
                        state_q   <= RUN;
                        div_q     <= op[1];
                        a_q       <= abs_a;
                        b_q       <= abs_b;
                        neg_q     <= sgn_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        rem_neg_q <= sgn_op & operand_a[WIDTH-1];
                        // Low half carries the multiplier or dividend; it is consumed as bits shift out.
                        acc_q     <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt_q     <= '0;
                    end else if (start && op[1:0] == 2'b00) begin
                        hi_q <= operand_a;
                    end else if (start && op[1:0] == 2'b01) begin
                        lo_q <= operand_a;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
